// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// UART_TX_TWO_STOP_EN selects two stop bits instead of one.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity for the latched TX word; forced low when parity is off.
import uart_pkg::*;

module uart_parity_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  enable,
    input  logic                  mode,
    output logic                  parity
);

    always_comb begin
        parity = 1'b0;
        if (enable) begin
            parity = (mode == PAR_ODD) ? ~^data : ^data;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit framer: start, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN for two stop bits.
import uart_pkg::*;

module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  parity_en,
    input  logic                  parity_mode,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [PS_W-1:0]  LAST_TICK = PS_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(NSTOP - 1);

    uart_state_t           state;
    uart_state_t           next_state;
    logic [PS_W-1:0]       ps_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pen_q;
    logic                  pmode_q;
    logic                  parity_bit;
    logic                  line_bit;
    logic                  bit_tick;

    uart_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data   (data_q),
        .enable (pen_q),
        .mode   (pmode_q),
        .parity (parity_bit)
    );

    assign bit_tick = (ps_cnt == LAST_TICK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // bit_idx doubles as the stop-bit counter while in STOP
    always_comb begin
        next_state = state;
        line_bit   = STOP_BIT;
        unique case (state)
            IDLE: begin
                if (data_valid) next_state = START;
            end
            START: begin
                line_bit = START_BIT;
                if (bit_tick) next_state = DATA;
            end
            DATA: begin
                line_bit = data_q[bit_idx];
                if (bit_tick && bit_idx == LAST_BIT) next_state = pen_q ? PARITY : STOP;
            end
            PARITY: begin
                line_bit = parity_bit;
                if (bit_tick) next_state = STOP;
            end
            STOP: begin
                line_bit = STOP_BIT;
                if (bit_tick && bit_idx == LAST_STOP) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered copies of the current state's line level, so they lag the state by one clock
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt  <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            pmode_q <= 1'b0;
            tx_out  <= STOP_BIT;
            busy    <= 1'b0;
        end else begin
            tx_out <= line_bit;
            busy   <= (state != IDLE);
            if (state == IDLE && data_valid) begin
                data_q  <= p_data;
                pen_q   <= parity_en;
                pmode_q <= parity_mode;
            end
            if (next_state != state) begin
                ps_cnt  <= '0;
                bit_idx <= '0;
            end else if (state != IDLE) begin
                if (bit_tick) begin
                    ps_cnt  <= '0;
                    bit_idx <= bit_idx + 1'b1;
                end else begin
                    ps_cnt <= ps_cnt + 1'b1;
                end
            end
        end
    end

endmodule
